rgb2hsv_pipe: RTL and testbench

RGB2HSV_PIPE -- requirements
Module: rgb2hsv_pipe

---
 rtl/rgb2hsv_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_rgb2hsv_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2hsv_pipe.sv
// Pipelined RGB to HSV converter: min/max stage, dividend setup stage, two
// DATA_W-stage restoring dividers (hue, saturation), and a final hue assembly stage.
module rgb2hsv_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk_Image_Process,
    input  logic              Rst,
    input  logic              Pix_En,
    input  logic              In_Valid,
    input  logic              In_Hsync,
    input  logic              In_Vsync,
    input  logic [DATA_W-1:0] RGB_Data_R,
    input  logic [DATA_W-1:0] RGB_Data_G,
    input  logic [DATA_W-1:0] RGB_Data_B,
    output logic [8:0]        HSV_H,
    output logic [DATA_W-1:0] HSV_S,
    output logic [DATA_W-1:0] HSV_V,
    output logic              Out_Valid,
    output logic              Out_Hsync,
    output logic              Out_Vsync,
    output logic [4:0]        Delay_Num
);

    localparam int LATENCY = DATA_W + 3;
    localparam int HW      = 2 * DATA_W + 6;
    localparam int SW      = 2 * DATA_W;
    localparam logic [DATA_W-1:0] FULL = '1;

    typedef enum logic [1:0] {SRC_R, SRC_G, SRC_B} src_e;

    logic [DATA_W-1:0] r1_q, g1_q, b1_q, max1_q, min1_q, max1_d, min1_d;
    src_e              src1_q, src1_d;

    logic [DATA_W-1:0] delta_d, diff_d;

    // Index 0 is the dividend-setup stage, index k+1 is divider stage k.
    logic [HW-1:0]     hrem_q [DATA_W+1];
    logic [HW-1:0]     hrem_d [DATA_W+1];
    logic [DATA_W-1:0] hdiv_q [DATA_W+1];
    logic [DATA_W-1:0] hdiv_d [DATA_W+1];
    logic [DATA_W-1:0] hquo_q [DATA_W+1];
    logic [DATA_W-1:0] hquo_d [DATA_W+1];
    logic [SW-1:0]     srem_q [DATA_W+1];
    logic [SW-1:0]     srem_d [DATA_W+1];
    logic [DATA_W-1:0] sdiv_q [DATA_W+1];
    logic [DATA_W-1:0] sdiv_d [DATA_W+1];
    logic [DATA_W-1:0] squo_q [DATA_W+1];
    logic [DATA_W-1:0] squo_d [DATA_W+1];
    logic              add_q  [DATA_W+1];
    logic              add_d  [DATA_W+1];
    logic [8:0]        base_q [DATA_W+1];
    logic [8:0]        base_d [DATA_W+1];
    logic [DATA_W-1:0] val_q  [DATA_W+1];
    logic [DATA_W-1:0] val_d  [DATA_W+1];
    logic [HW-1:0]     hsh;
    logic [SW-1:0]     ssh;

    logic [2:0]        sb_q [LATENCY];
    logic [8:0]        hsum, h_d, h_q;
    logic [DATA_W-1:0] s_q, v_q;

    always_comb begin
        src1_d = SRC_B;
        max1_d = RGB_Data_B;
        if (RGB_Data_R >= RGB_Data_G && RGB_Data_R >= RGB_Data_B) begin
            src1_d = SRC_R;
            max1_d = RGB_Data_R;
        end else if (RGB_Data_G >= RGB_Data_B) begin
            src1_d = SRC_G;
            max1_d = RGB_Data_G;
        end
        min1_d = RGB_Data_R;
        if (RGB_Data_G < min1_d) min1_d = RGB_Data_G;
        if (RGB_Data_B < min1_d) min1_d = RGB_Data_B;
    end

    always_comb begin
        delta_d   = max1_q - min1_q;
        diff_d    = '0;
        base_d[0] = 9'd0;
        add_d[0]  = 1'b1;
        case (src1_q)
            SRC_R: begin
                if (g1_q >= b1_q) begin
                    diff_d = g1_q - b1_q;
                end else begin
                    base_d[0] = 9'd360;
                    diff_d    = b1_q - g1_q;
                    add_d[0]  = 1'b0;
                end
            end
            SRC_G: begin
                base_d[0] = 9'd120;
                if (b1_q > r1_q) begin
                    diff_d = b1_q - r1_q;
                end else begin
                    diff_d   = r1_q - b1_q;
                    add_d[0] = 1'b0;
                end
            end
            default: begin
                base_d[0] = 9'd240;
                if (r1_q > g1_q) begin
                    diff_d = r1_q - g1_q;
                end else begin
                    diff_d   = g1_q - r1_q;
                    add_d[0] = 1'b0;
                end
            end
        endcase
        hrem_d[0] = HW'(diff_d) * HW'(60);
        hdiv_d[0] = delta_d;
        srem_d[0] = SW'(delta_d) * SW'(FULL);
        sdiv_d[0] = max1_q;
        // Grey pixel: hue is undefined, force 0/1 so the dividers yield 0.
        if (delta_d == '0) begin
            hrem_d[0] = '0;
            hdiv_d[0] = DATA_W'(1);
            srem_d[0] = '0;
            sdiv_d[0] = DATA_W'(1);
            base_d[0] = 9'd0;
        end
        hquo_d[0] = '0;
        squo_d[0] = '0;
        val_d[0]  = max1_q;

        hsh = '0;
        ssh = '0;
        for (int k = 0; k < DATA_W; k++) begin
            hsh           = HW'(hdiv_q[k]) << (DATA_W - 1 - k);
            ssh           = SW'(sdiv_q[k]) << (DATA_W - 1 - k);
            hrem_d[k+1]   = hrem_q[k];
            hquo_d[k+1]   = hquo_q[k];
            srem_d[k+1]   = srem_q[k];
            squo_d[k+1]   = squo_q[k];
            if (hrem_q[k] >= hsh) begin
                hrem_d[k+1]               = hrem_q[k] - hsh;
                hquo_d[k+1][DATA_W-1-k]   = 1'b1;
            end
            if (srem_q[k] >= ssh) begin
                srem_d[k+1]               = srem_q[k] - ssh;
                squo_d[k+1][DATA_W-1-k]   = 1'b1;
            end
            hdiv_d[k+1] = hdiv_q[k];
            sdiv_d[k+1] = sdiv_q[k];
            add_d[k+1]  = add_q[k];
            base_d[k+1] = base_q[k];
            val_d[k+1]  = val_q[k];
        end

        // Hue quotient never exceeds 60, so the sum/difference stays within 0..360.
        hsum = add_q[DATA_W] ? base_q[DATA_W] + 9'(hquo_q[DATA_W])
                             : base_q[DATA_W] - 9'(hquo_q[DATA_W]);
        h_d  = (hsum == 9'd360) ? 9'd0 : hsum;
    end

    always_ff @(posedge clk_Image_Process) begin
        if (Rst) begin
            r1_q   <= '0;
            g1_q   <= '0;
            b1_q   <= '0;
            max1_q <= '0;
            min1_q <= '0;
            src1_q <= SRC_R;
            for (int k = 0; k <= DATA_W; k++) begin
                hrem_q[k] <= '0;
                hdiv_q[k] <= DATA_W'(1);
                hquo_q[k] <= '0;
                srem_q[k] <= '0;
                sdiv_q[k] <= DATA_W'(1);
                squo_q[k] <= '0;
                add_q[k]  <= 1'b0;
                base_q[k] <= '0;
                val_q[k]  <= '0;
            end
            for (int k = 0; k < LATENCY; k++) sb_q[k] <= '0;
            h_q <= '0;
            s_q <= '0;
            v_q <= '0;
        end else if (Pix_En) begin
            r1_q   <= RGB_Data_R;
            g1_q   <= RGB_Data_G;
            b1_q   <= RGB_Data_B;
            max1_q <= max1_d;
            min1_q <= min1_d;
            src1_q <= src1_d;
            for (int k = 0; k <= DATA_W; k++) begin
                hrem_q[k] <= hrem_d[k];
                hdiv_q[k] <= hdiv_d[k];
                hquo_q[k] <= hquo_d[k];
                srem_q[k] <= srem_d[k];
                sdiv_q[k] <= sdiv_d[k];
                squo_q[k] <= squo_d[k];
                add_q[k]  <= add_d[k];
                base_q[k] <= base_d[k];
                val_q[k]  <= val_d[k];
            end
            sb_q[0] <= {In_Valid, In_Hsync, In_Vsync};
            for (int k = 1; k < LATENCY; k++) sb_q[k] <= sb_q[k-1];
            h_q <= h_d;
            s_q <= squo_q[DATA_W];
            v_q <= val_q[DATA_W];
        end
    end

    assign HSV_H     = h_q;
    assign HSV_S     = s_q;
    assign HSV_V     = v_q;
    assign Out_Valid = sb_q[LATENCY-1][2];
    assign Out_Hsync = sb_q[LATENCY-1][1];
    assign Out_Vsync = sb_q[LATENCY-1][0];
    assign Delay_Num = 5'(LATENCY);

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Bench for rgb2hsv_pipe: fixed vectors, randomized stream against an
// arithmetic HSV model with an enabled-cycle delay line, reset and DATA_W=10 cases.
module tb_rgb2hsv_pipe;

    localparam int W     = 8;
    localparam int LAT   = W + 3;
    localparam int LAT10 = 13;

    logic       clk = 1'b0;
    logic       rst, en, vld, hs, vs;
    logic [7:0] r, g, b;
    logic [8:0] h;
    logic [7:0] s, v;
    logic       ov, ohs, ovs;
    logic [4:0] dn;

    logic       vld10;
    logic [9:0] r10, g10, b10;
    logic [8:0] h10;
    logic [9:0] s10, v10;
    logic       ov10, ohs10, ovs10;
    logic [4:0] dn10;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rgb2hsv_pipe #(.DATA_W(8)) dut (
        .clk_Image_Process(clk), .Rst(rst), .Pix_En(en), .In_Valid(vld),
        .In_Hsync(hs), .In_Vsync(vs), .RGB_Data_R(r), .RGB_Data_G(g), .RGB_Data_B(b),
        .HSV_H(h), .HSV_S(s), .HSV_V(v), .Out_Valid(ov), .Out_Hsync(ohs),
        .Out_Vsync(ovs), .Delay_Num(dn)
    );

    rgb2hsv_pipe #(.DATA_W(10)) dut10 (
        .clk_Image_Process(clk), .Rst(rst), .Pix_En(en), .In_Valid(vld10),
        .In_Hsync(hs), .In_Vsync(vs), .RGB_Data_R(r10), .RGB_Data_G(g10), .RGB_Data_B(b10),
        .HSV_H(h10), .HSV_S(s10), .HSV_V(v10), .Out_Valid(ov10), .Out_Hsync(ohs10),
        .Out_Vsync(ovs10), .Delay_Num(dn10)
    );

    typedef struct { int r, g, b, h, s, v; } vec_t;
    typedef struct { bit v, hs, vs; int h, s, vv; } exp_t;

    vec_t tbl[8];
    exp_t mq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void ref_hsv(input int ir, input int ig, input int ib, input int w,
                                    output int oh, output int os, output int ov_);
        int mx, mn, d;
        mx  = (ir > ig) ? ir : ig;
        mx  = (mx > ib) ? mx : ib;
        mn  = (ir < ig) ? ir : ig;
        mn  = (mn < ib) ? mn : ib;
        d   = mx - mn;
        ov_ = mx;
        if (d == 0) begin
            oh = 0;
            os = 0;
        end else begin
            os = ((2 ** w - 1) * d) / mx;
            if (mx == ir)      oh = (ig >= ib) ? 60 * (ig - ib) / d : 360 - 60 * (ib - ig) / d;
            else if (mx == ig) oh = (ib > ir) ? 120 + 60 * (ib - ir) / d : 120 - 60 * (ir - ib) / d;
            else               oh = (ir > ig) ? 240 + 60 * (ir - ig) / d : 240 - 60 * (ig - ir) / d;
            if (oh == 360) oh = 0;
        end
    endfunction

    task automatic model_reset();
        exp_t z;
        z = '{v: 0, hs: 0, vs: 0, h: 0, s: 0, vv: 0};
        mq.delete();
        for (int i = 0; i < LAT; i++) mq.push_back(z);
    endtask

    task automatic tick(input bit e, input bit rs, input bit iv, input bit ih, input bit ivs,
                        input int ir, input int ig, input int ib);
        exp_t x;
        en = e; rst = rs; vld = iv; hs = ih; vs = ivs;
        r = ir[7:0]; g = ig[7:0]; b = ib[7:0];
        if (rs) begin
            model_reset();
        end else if (e) begin
            x.v = iv; x.hs = ih; x.vs = ivs;
            ref_hsv(ir, ig, ib, W, x.h, x.s, x.vv);
            mq.push_back(x);
            void'(mq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, int'(ov), int'(mq[0].v));
        chk({tag, "_hsync"}, int'(ohs), int'(mq[0].hs));
        chk({tag, "_vsync"}, int'(ovs), int'(mq[0].vs));
        if (mq[0].v) begin
            chk({tag, "_h"}, int'(h), mq[0].h);
            chk({tag, "_s"}, int'(s), mq[0].s);
            chk({tag, "_v"}, int'(v), mq[0].vv);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, seen, k, first, idx;
        bit e;

        tbl[0] = '{255,   0,   0,   0, 255, 255};
        tbl[1] = '{  0, 200, 100, 150, 255, 200};
        tbl[2] = '{ 50, 100, 200, 220, 191, 200};
        tbl[3] = '{255,   0, 128, 330, 255, 255};
        tbl[4] = '{128, 128, 128,   0,   0, 128};
        tbl[5] = '{  0,   0,   0,   0,   0,   0};
        tbl[6] = '{200,  10,  11,   0, 242, 200};
        tbl[7] = '{255, 255,   0,  60, 255, 255};

        rst = 1'b1; en = 1'b0; vld = 1'b0; hs = 1'b0; vs = 1'b0;
        r = '0; g = '0; b = '0;
        vld10 = 1'b0; r10 = '0; g10 = '0; b10 = '0;
        model_reset();
        @(negedge clk);

        // Reset with Pix_En low still clears everything.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9, 9, 9);
        chk("rst_h", int'(h), 0);
        chk("rst_s", int'(s), 0);
        chk("rst_v", int'(v), 0);
        chk("rst_valid", int'(ov), 0);
        chk("rst_hsync", int'(ohs), 0);
        chk("rst_vsync", int'(ovs), 0);
        chk("delay_num8", int'(dn), LAT);
        chk("delay_num10", int'(dn10), LAT10);

        // Fixed vectors back-to-back, each expected exactly LAT cycles later.
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, tbl[i].r, tbl[i].g, tbl[i].b);
            else       tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            if (i + 1 == LAT - 1) chk("vec_early_valid", int'(ov), 0);
            idx = i + 1 - LAT;
            if (idx >= 0 && idx < 8) begin
                chk($sformatf("vec%0d_valid", idx), int'(ov), 1);
                chk($sformatf("vec%0d_h", idx), int'(h), tbl[idx].h);
                chk($sformatf("vec%0d_s", idx), int'(s), tbl[idx].s);
                chk($sformatf("vec%0d_v", idx), int'(v), tbl[idx].v);
            end
        end

        // DATA_W=10 instance: full red.
        r10 = 10'd1023; g10 = '0; b10 = '0; vld10 = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        vld10 = 1'b0; r10 = '0;
        for (int j = 2; j <= LAT10; j++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            if (j == LAT10 - 1) chk("w10_early_valid", int'(ov10), 0);
        end
        chk("w10_valid", int'(ov10), 1);
        chk("w10_h", int'(h10), 0);
        chk("w10_s", int'(s10), 1023);
        chk("w10_v", int'(v10), 1023);

        // Random stream of 20 pixels with Pix_En gaps and sync pulses.
        sent = 0;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            e = (c % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick(e, 1'b0, sent < 20, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            if (e && sent < 20) sent++;
            check_model("stream");
            if (e && ov) seen++;
        end
        chk("stream_count", seen, 20);

        // Reset mid-stream: in-flight pixels are dropped.
        for (int c = 0; c < 6; c++)
            tick(1'b1, 1'b0, 1'b1, c[0], c[1], $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10, 20, 30);
        chk("mrst_h", int'(h), 0);
        chk("mrst_s", int'(s), 0);
        chk("mrst_v", int'(v), 0);
        chk("mrst_valid", int'(ov), 0);
        chk("mrst_hsync", int'(ohs), 0);
        chk("mrst_vsync", int'(ovs), 0);
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            check_model("post_rst_idle");
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 90, 30, 200);
        check_model("post_rst");
        k = 1;
        first = ov ? 1 : -1;
        for (int c = 0; c < 40; c++) begin
            e = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick(e, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            check_model("post_rst");
            if (e) k++;
            if (ov && first < 0) first = k;
        end
        chk("post_rst_latency", first, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
